reg_pipe: RTL and testbench
===========================

// Module: reg_pipe
// PURPOSE
//  Parametrised chain of Depth data registers, each stage carrying a valid bit.
//  Uses a valid/ready handshake on both sides.
//  Bubble-collapsing: an empty stage always loads from upstream, even while the output is stalled.
//  Sits between datapath blocks for timing retiming and short-burst elasticity.
//  Sustains 1 word/cycle when the downstream never stalls.
// PARAMETERS
//  Size   8  data width in bits (>=1)
//  Depth  2  number of register stages (>=1); also the maximum number of words held
// PORTS
//  clock    in   1                      rising-edge clock
//  reset    in   1                      synchronous, active-high reset
//  data_i   in   Size                   upstream data
//  valid_i  in   1                      upstream data valid
//  ready_o  out  1                      pipe accepts data_i this cycle
//  data_o   out  Size                   data of the last stage
//  valid_o  out  1                      last stage holds a word
//  ready_i  in   1                      downstream accepts data_o this cycle
//  fill_o   out  $clog2(Depth+1)        number of valid stages, 0..Depth
//  flush    in   1                      only present with REG_PIPE_FLUSH_EN
// BEHAVIOUR
//  Reset, clock: reset is synchronous, active-high; the clock is clock.
//  Reset values: all stage valids 0, all stage data 0.
//   Hence valid_o=0, data_o=0, fill_o=0, ready_o=1 in the cycle after reset.
//  Stage numbering: stage 0 is the input stage; stage Depth-1 drives data_o/valid_o.
//  Move terms:
//   mv[Depth-1] = valid[Depth-1] & ready_i
//   mv[k]       = valid[k] & (~valid[k+1] | mv[k+1])
//  Ready: ready_o = ~valid[0] | mv[0].
//   Combinational from ready_i; a chain of at most Depth gate levels.
//  Accept: a word is accepted when valid_i & ready_o; stage 0 loads data_i.
//  Stage k>0 loads from stage k-1 when mv[k-1].
//  Valid update per stage:
//   valid[k]' = load_k | (valid[k] & ~mv[k])
//  Data registers change only on load; otherwise they hold.
//   Data in empty stages is stale; data_o is meaningful only with valid_o=1.
//  Latency: a word accepted at edge t reaches valid_o no earlier than edge t+Depth-1.
//   Minimum accept-to-output is Depth cycles.
//  Empty pipe: ready_o=1 regardless of ready_i.
//  Full pipe (fill_o=Depth):
//   ready_i=0 -> ready_o=0, all stages hold.
//   ready_i=1 -> ready_o=1; accept and emit in the same cycle; fill_o unchanged.
//  Stall with bubbles: while ready_i=0, words advance into empty stages until packed at the output end.
//  Ordering: strictly FIFO; no word is duplicated or dropped.
//  fill_o is registered; it equals the population count of valid bits after each edge.
//  Reset mid-operation: all held words are discarded at the next edge; nothing is emitted.
//  Reset has priority over every other input.
// CONFIGURATION
//  REG_PIPE_FLUSH_EN defined:
//   The flush port exists; flush=1 clears every valid bit at the next edge and fill_o becomes 0.
//   Data registers are not cleared.
//   ready_o=0 while flush=1, so no word is accepted during a flush cycle.
//   The output word is not consumed during a flush cycle, even if ready_i=1.
//   Priority: reset > flush > normal operation.
//  REG_PIPE_FLUSH_EN undefined:
//   No flush port and no flush logic; behaviour is exactly as above.
// TESTING  (Size=8, Depth=3 unless stated)
//  1 Reset: hold reset 2 cycles with valid_i=1.
//     -> valid_o=0, data_o=0, fill_o=0, ready_o=1; nothing accepted.
//  2 Streaming: ready_i=1; send 0x01..0x10 on consecutive cycles.
//     -> 0x01 appears 3 cycles after its accept; then one word per cycle in order; ready_o stays 1.
//  3 Backpressure fill: ready_i=0; send 0xA1,0xA2,0xA3,0xA4.
//     -> fill_o=3; ready_o=0 on 0xA4; 0xA4 is held off.
//     Set ready_i=1 -> output A1,A2,A3,A4 in order, no gaps.
//  4 Full pass-through: pipe full, ready_i=1, valid_i=1.
//     -> accept and emit each cycle; fill_o stays 3.
//  5 Bubble collapse: send 0x11, idle 2 cycles, send 0x22, all with ready_i=0.
//     -> after 3 more cycles fill_o=2; 0x11 in stage 2, 0x22 in stage 1; ready_o=1.
//  6 Reset with a full pipe (and, with REG_PIPE_FLUSH_EN, flush=1 with valid_i=1):
//     -> next cycle fill_o=0, valid_o=0; input word not accepted; later streams are unaffected.

Source files
------------

// File: rtl/reg_pipe.sv
// rtl/reg_pipe.sv - bubble-collapsing valid/ready register pipeline of Depth stages
// Optional flush port and logic enabled by defining REG_PIPE_FLUSH_EN.
module reg_pipe #(
    parameter int Size  = 8,
    parameter int Depth = 2
) (
    input  logic                       clock,
    input  logic                       reset,
`ifdef REG_PIPE_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic [Size-1:0]            data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [Size-1:0]            data_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(Depth+1)-1:0] fill_o
);

    localparam int FillW = $clog2(Depth + 1);

    logic [Depth-1:0] valid;
    logic [Depth-1:0] valid_n;
    logic [Depth-1:0] mv;
    logic [Depth-1:0] load;
    logic [Size-1:0]  data [Depth];
    logic [FillW-1:0] fill_n;
    logic             kill;

`ifdef REG_PIPE_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    // mv[k]: stage k hands its word onward this cycle; a full stage may
    // still move if everything ahead of it is moving too.
    always_comb begin
        mv              = '0;
        mv[Depth-1]     = valid[Depth-1] & ready_i & ~kill;
        for (int k = Depth - 2; k >= 0; k--) begin
            mv[k] = valid[k] & (~valid[k+1] | mv[k+1]);
        end
        ready_o = (~valid[0] | mv[0]) & ~kill;
        load    = '0;
        load[0] = valid_i & ready_o;
        for (int k = 1; k < Depth; k++) begin
            load[k] = mv[k-1];
        end
        valid_n = '0;
        fill_n  = '0;
        for (int k = 0; k < Depth; k++) begin
            valid_n[k] = ~kill & (load[k] | (valid[k] & ~mv[k]));
            fill_n     = fill_n + FillW'(valid_n[k]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid  <= '0;
            fill_o <= '0;
            for (int k = 0; k < Depth; k++) begin
                data[k] <= '0;
            end
        end else begin
            valid  <= valid_n;
            fill_o <= fill_n;
            if (load[0]) begin
                data[0] <= data_i;
            end
            for (int k = 1; k < Depth; k++) begin
                if (load[k]) begin
                    data[k] <= data[k-1];
                end
            end
        end
    end

    assign data_o  = data[Depth-1];
    assign valid_o = valid[Depth-1];

endmodule

// File: tb/tb_reg_pipe.sv
// tb/tb_reg_pipe.sv - table-driven scoreboard bench for reg_pipe (Size=8, Depth=3)
module tb_reg_pipe;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_i = '0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i = 1'b0;
    logic [1:0] fill_o;
    logic       fl = 1'b0;

    reg_pipe #(.Size(8), .Depth(3)) dut (
        .clock   (clock),
        .reset   (reset),
`ifdef REG_PIPE_FLUSH_EN
        .flush   (fl),
`endif
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .fill_o  (fill_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       rst;
        logic       e_rdy;
        logic       e_vld;
        logic [7:0] e_dat;
        int         e_fill;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] sb[$];
    int n_cmp = 0, n_fail = 0, cyc = 0, n_emit = 0;
    int first_acc = -1, first_emit = -1, last_emit = -1;
    logic       s_rdy, s_vld;
    logic [7:0] s_dat;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic r, input logic rst,
                       input logic e_rdy, input logic e_vld, input logic [7:0] e_dat,
                       input int e_fill);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.rst = rst;
        t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_dat = e_dat; t.e_fill = e_fill;
        tbl.push_back(t);
    endtask

    // One clock: drive at negedge, sample outputs, update scoreboard, check fill after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic rst);
        logic [7:0] e;
        @(negedge clock);
        valid_i = v; data_i = d; ready_i = r; reset = rst;
        #1;
        s_rdy = ready_o; s_vld = valid_o; s_dat = data_o;
        if (!rst && !fl && s_vld && r) begin
            n_emit++;
            if (first_emit < 0) first_emit = cyc;
            last_emit = cyc;
            if (sb.size() == 0) begin
                chk("sb_spurious_emit", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_data", int'(s_dat), int'(e));
            end
        end
        if (!rst && !fl && v && s_rdy) begin
            sb.push_back(d);
            if (first_acc < 0) first_acc = cyc;
        end
        if (rst || fl) sb.delete();
        @(posedge clock);
        #1;
        chk("sb_fill", int'(fill_o), sb.size());
        cyc++;
    endtask

    initial begin
        // backpressure fill, then held-off word
        add(1, 8'hA1, 0, 0, 1, 0, 8'h00, 1);
        add(1, 8'hA2, 0, 0, 1, 0, 8'h00, 2);
        add(1, 8'hA3, 0, 0, 1, 0, 8'h00, 3);
        add(1, 8'hA4, 0, 0, 0, 1, 8'hA1, 3);
        add(1, 8'hA4, 0, 0, 0, 1, 8'hA1, 3);
        add(1, 8'hA4, 1, 0, 1, 1, 8'hA1, 3);
        // full pass-through
        add(1, 8'hB1, 1, 0, 1, 1, 8'hA2, 3);
        add(1, 8'hB2, 1, 0, 1, 1, 8'hA3, 3);
        add(1, 8'hB3, 1, 0, 1, 1, 8'hA4, 3);
        // reset with full pipe and a word offered
        add(1, 8'hC1, 0, 1, 0, 1, 8'hB1, 0);
        add(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
        // bubble collapse under stall, then drain
        add(1, 8'h11, 0, 0, 1, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 1, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 1, 0, 8'h00, 1);
        add(1, 8'h22, 0, 0, 1, 1, 8'h11, 2);
        add(0, 8'h00, 0, 0, 1, 1, 8'h11, 2);
        add(0, 8'h00, 0, 0, 1, 1, 8'h11, 2);
        add(0, 8'h00, 0, 0, 1, 1, 8'h11, 2);
        add(0, 8'h00, 1, 0, 1, 1, 8'h11, 1);
        add(0, 8'h00, 1, 0, 1, 1, 8'h22, 0);
        add(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);

        // reset held 2 cycles with valid_i=1
        step(1, 8'h55, 1, 1);
        step(1, 8'h55, 1, 1);
        @(negedge clock);
        valid_i = 0; reset = 0; ready_i = 0;
        #1;
        chk("rst_valid_o", int'(valid_o), 0);
        chk("rst_data_o", int'(data_o), 0);
        chk("rst_fill_o", int'(fill_o), 0);
        chk("rst_ready_o", int'(ready_o), 1);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].rst);
            chk($sformatf("vec%0d_ready_o", i), int'(s_rdy), int'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_valid_o", i), int'(s_vld), int'(tbl[i].e_vld));
            if (tbl[i].e_vld) chk($sformatf("vec%0d_data_o", i), int'(s_dat), int'(tbl[i].e_dat));
            chk($sformatf("vec%0d_fill_o", i), int'(fill_o), tbl[i].e_fill);
        end

        // streaming at full rate after the reset above
        first_acc = -1; first_emit = -1; last_emit = -1; n_emit = 0;
        for (int i = 1; i <= 16; i++) begin
            step(1, 8'(i), 1, 0);
            chk("stream_ready_o", int'(s_rdy), 1);
        end
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0);
        chk("stream_latency", first_emit - first_acc, 3);
        chk("stream_count", n_emit, 16);
        chk("stream_no_gaps", last_emit - first_emit, 15);
        chk("stream_sb_empty", sb.size(), 0);

`ifdef REG_PIPE_FLUSH_EN
        step(1, 8'h31, 0, 0);
        step(1, 8'h32, 0, 0);
        fl = 1'b1;
        step(1, 8'h33, 1, 0);
        chk("flush_ready_o", int'(s_rdy), 0);
        chk("flush_fill_o", int'(fill_o), 0);
        chk("flush_valid_o", int'(valid_o), 0);
        fl = 1'b0;
        step(1, 8'h34, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
        chk("flush_after_sb_empty", sb.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
